// File: rtl/atax_inv_pkg.sv
// Shared types and default widths for the atax call sequencer.
// The job_t payload is sized by ADDR_W_DEF; instances must keep ADDR_W equal to it.
package atax_inv_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int CYC_W_DEF  = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] A;
    logic [ADDR_W_DEF-1:0] x;
    logic [ADDR_W_DEF-1:0] y_out;
  } job_t;

endpackage

// File: rtl/atax_invoker_if.sv
// Call/return port bundle between the sequencer (master) and the atax component (slave).
interface atax_invoker_if
  import atax_inv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] A;
  logic [ADDR_W-1:0] x;
  logic [ADDR_W-1:0] y_out;
  logic              done;
  logic              stall;

  modport master (output start, A, x, y_out, stall, input busy, done);
  modport slave  (input start, A, x, y_out, stall, output busy, done);

endinterface

// File: rtl/atax_job_fifo.sv
// Synchronous job FIFO; the head is read from registered storage, so a pushed
// entry is first visible the cycle after the push (no pass-through).
module atax_job_fifo
  import atax_inv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  job_t wr_data,
  output job_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  job_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/atax_invoker.sv
// Upstream call sequencer for the atax component: queues job descriptors, issues
// one call at a time, times each call and publishes one result record per job.
module atax_invoker
  import atax_inv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CYC_W  = CYC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_A,
  input  logic [ADDR_W-1:0] job_x,
  input  logic [ADDR_W-1:0] job_y_out,
  atax_invoker_if.master    call,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CYC_W-1:0]  res_cycles,
  output logic [CNT_W-1:0]  jobs_done,
  output logic              idle,
  output logic              proto_err
);

  state_t           state;
  logic [CYC_W-1:0] cyc;
  job_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ret_acc;

  assign job_ready  = !full;
  assign push       = job_valid && !full;
  assign pop        = (state == ISSUE) && call.start && !call.busy;
  assign call.stall = res_valid && !res_ready;
  assign ret_acc    = (state == WAIT) && call.done && !call.stall;
  assign idle       = empty && (state == IDLE) && !res_valid;

  atax_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push),
    .pop     (pop),
    .wr_data ('{A: job_A, x: job_x, y_out: job_y_out}),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      call.start <= 1'b0;
      call.A     <= '0;
      call.x     <= '0;
      call.y_out <= '0;
      cyc        <= '0;
      res_valid  <= 1'b0;
      res_cycles <= '0;
      jobs_done  <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (call.done && (state != WAIT)) proto_err <= 1'b1;
      // A return accepted in WAIT below overrides this clear with fresh data.
      if (res_valid && res_ready) res_valid <= 1'b0;

      // NOTE: every branch either assigns or holds a register, and the default arm
      // recovers illegal encodings, so no latch or stuck state can be inferred.
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= ISSUE;
            call.start <= 1'b1;
            call.A     <= head.A;
            call.x     <= head.x;
            call.y_out <= head.y_out;
          end
        end
        ISSUE: begin
          if (!call.busy) begin
            call.start <= 1'b0;
            cyc        <= CYC_W'(1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cyc != '1) cyc <= cyc + 1'b1;
          if (ret_acc) begin
            res_cycles <= cyc;
            res_valid  <= 1'b1;
            jobs_done  <= jobs_done + 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          call.start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/atax_invoker.md
Name: atax_invoker

Overview:
- Upstream call sequencer for the atax HLS component.
- Buffers job descriptors (base pointers A, x, y_out) in a small FIFO and issues them one at a time over the component's call interface (start/busy).
- Accepts each return (done/stall), measures call-to-return cycles and publishes one result record per job.
- Sits between the host/testbench job source and the atax component's call, return and argument ports.

Parameters:
- ADDR_W, 64, width of each pointer argument.
- DEPTH, 4, job FIFO entries (power of two, ≥2).
- CYC_W, 32, width of per-job cycle count.
- CNT_W, 16, width of completed-job counter.

Ports:
- clock  in  1  single clock for the block.
- resetn  in  1  reset, synchronous, active-low.
- job_valid  in  1  job descriptor offered.
- job_ready  out  1  FIFO can accept (= !full).
- job_A  in  ADDR_W  matrix A base address.
- job_x  in  ADDR_W  vector x base address.
- job_y_out  in  ADDR_W  result vector base address.
- start  out  1  call valid to component.
- busy  in  1  component call stall.
- A  out  ADDR_W  argument to component.
- x  out  ADDR_W  argument to component.
- y_out  out  ADDR_W  argument to component.
- done  in  1  component return valid.
- stall  out  1  return stall to component.
- res_valid  out  1  result record valid.
- res_ready  in  1  result consumer ready.
- res_cycles  out  CYC_W  cycles from call accept to return accept.
- jobs_done  out  CNT_W  completed-job count, wraps.
- idle  out  1  FIFO empty, FSM IDLE, no pending result.
- proto_err  out  1  sticky: done seen outside WAIT.

Behaviour:
- Reset is sampled on the clock edge only. While resetn=0 at an edge:
  - FSM goes to IDLE and the FIFO is flushed.
  - start=0, res_valid=0, res_cycles=0, jobs_done=0, proto_err=0, A/x/y_out=0.
  - Reset mid-call abandons the job; no result is produced.
- FIFO:
  - Push on job_valid && job_ready. Pop on call acceptance.
  - No pass-through: an entry is visible to the FSM the cycle after it is pushed.
  - job_ready=0 when full; push and pop in the same cycle is legal whenever not full.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE: FIFO non-empty → ISSUE, and A/x/y_out are loaded from the FIFO head.
  - ISSUE: start=1. Call accepted when start && !busy; on acceptance pop the FIFO, set cyc=1 and go to WAIT. Hold start and arguments while busy=1.
  - WAIT: start=0. A/x/y_out are held stable until the return is accepted. cyc increments every cycle and saturates at 2^CYC_W-1.
- Return path:
  - stall = res_valid && !res_ready (combinational).
  - Return accepted when state==WAIT && done && !stall. In that cycle:
    - res_cycles <= cyc, res_valid <= 1;
    - jobs_done increments, wrapping;
    - FSM returns to IDLE.
  - With the FIFO non-empty, the earliest next start is 2 cycles after return acceptance (IDLE → ISSUE).
- Result handshake: res_valid clears on res_valid && res_ready unless a new return is accepted in the same cycle; in that case it stays 1 with new data. This case only arises when res_ready=1.
- Timing: latency from push into an empty idle block to start=1 is 2 cycles (push at edge k, IDLE sees entry in cycle k+1, start in cycle k+2).
- Protocol error: done=1 in IDLE or ISSUE sets proto_err, which holds until reset. FSM state is unaffected.
- Only one call is outstanding at any time.

Decomposition:
- Package atax_inv_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - default ADDR_W/CYC_W/CNT_W constants;
  - a packed job_t struct {A, x, y_out}.
- One sub-module, atax_job_fifo: parameterised synchronous FIFO of job_t with full/empty and a registered read head.

Test Plan:
- Single job {A=0x1000, x=0x2000, y_out=0x3000}, busy=0, done 10 cycles after acceptance, res_ready=1 → start high one cycle, args stable until done, res_cycles=10, jobs_done=1, idle=1 afterwards.
- busy=1 for 5 cycles during ISSUE → start and args held for 6 cycles, one acceptance, FIFO pops once.
- Push 5 jobs back-to-back with DEPTH=4 and component stalled → job_ready=0 after 4th push (and while 4 entries queued); all 5 jobs issued in order; jobs_done=5.
- res_ready=0 when second done arrives → stall=1, done held, no second result; raise res_ready → first result consumed, second accepted next cycle, res_cycles correct.
- resetn=0 for one edge during WAIT → all outputs to reset values, FIFO empty, no result; new job afterwards runs normally.
- done=1 pulsed while IDLE → proto_err=1 and stays 1; jobs_done unchanged.
